// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter.
//   uart_state_e : frame state encoding
//   PAR_EVEN/ODD : values of the parity-type select
//   majority3    : 2-of-3 vote used for mid-bit sampling
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : restart the divider and latch div for the coming frame
//   div  : clk cycles per tick minus 1 (0 -> tick every clk)
//   tick : one-clk pulse every div+1 clks after clr
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  // Down-counter with terminal count at zero; reloads from the divisor
  // captured at clr so mid-frame changes to div have no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clr) begin
      cnt   <= div;
      div_q <= div;
    end else if (cnt == '0) begin
      cnt <= div_q;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = ~clr & (cnt == '0);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   en         : receiver enable, low aborts the current frame
//   div        : clk cycles per oversample tick minus 1
//   par_en     : parity bit present
//   par_typ    : 0 even, 1 odd
//   stop2      : two stop bits expected
//   rx_in      : async serial line, idles high
//   p_data     : last received word
//   data_valid : one-clk strobe when p_data and the flags update
//   par_error  : parity mismatch on last frame
//   stop_error : a stop bit sampled low on last frame
//   busy       : frame in progress
//
// state     | meaning
// ST_IDLE   | waiting for a 1->0 edge on the synced line
// ST_START  | qualifying the start bit at mid-bit
// ST_DATA   | shifting in DATA_W bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking one or two stop bits, then strobing data_valid
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OS     = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic              stop2,
  input  logic              rx_in,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_error,
  output logic              stop_error,
  output logic              busy
);

  localparam int CNT_W = $clog2(OS);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] VOTE_A   = CNT_W'(OS/2 - 1);
  localparam logic [CNT_W-1:0] VOTE_B   = CNT_W'(OS/2);
  localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(OS/2 + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  uart_state_e       state;
  logic              rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0]  s_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              samp_a, samp_b;
  logic [DATA_W-1:0] shreg;
  logic              pbit;
  logic              stop_err_acc;
  logic              stop_second;
  logic              par_en_q, par_typ_q, stop2_q;
  logic              tick;
  logic              start_det;
  logic              at_vote, at_end;
  logic              voted;
  logic              stop_err_now;

  // Edge detect needs the previous synced level high, so a line held low
  // after a bad stop bit cannot retrigger until it has returned high.
  assign start_det    = en & (state == ST_IDLE) & rx_prev & ~rx_s2;
  assign at_vote      = tick & (s_cnt == VOTE_C);
  assign at_end       = tick & (s_cnt == CNT_LAST);
  assign voted        = majority3(samp_a, samp_b, rx_s2);
  assign stop_err_now = stop_err_acc | ~voted;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .div  (div),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      s_cnt        <= '0;
      bit_cnt      <= '0;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      shreg        <= '0;
      pbit         <= 1'b0;
      stop_err_acc <= 1'b0;
      stop_second  <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      stop2_q      <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      par_error    <= 1'b0;
      stop_error   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_s1      <= rx_in;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      data_valid <= 1'b0;

      if (!en) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        if (tick && state != ST_IDLE) begin
          s_cnt <= (s_cnt == CNT_LAST) ? '0 : s_cnt + 1'b1;
          if (s_cnt == VOTE_A) samp_a <= rx_s2;
          if (s_cnt == VOTE_B) samp_b <= rx_s2;
        end

        case (state)
          ST_IDLE: begin
            if (start_det) begin
              state        <= ST_START;
              busy         <= 1'b1;
              s_cnt        <= '0;
              bit_cnt      <= '0;
              stop_err_acc <= 1'b0;
              stop_second  <= 1'b0;
              par_en_q     <= par_en;
              par_typ_q    <= par_typ;
              stop2_q      <= stop2;
            end
          end

          ST_START: begin
            if (at_vote && voted) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (at_end) begin
              state <= ST_DATA;
            end
          end

          ST_DATA: begin
            if (at_vote) begin
              shreg   <= {voted, shreg[DATA_W-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (at_end && bit_cnt == BIT_LAST) begin
              state <= par_en_q ? ST_PARITY : ST_STOP;
            end
          end

          ST_PARITY: begin
            if (at_vote) pbit <= voted;
            if (at_end)  state <= ST_STOP;
          end

          ST_STOP: begin
            if (at_vote) begin
              if (stop2_q && !stop_second) begin
                stop_err_acc <= stop_err_now;
                stop_second  <= 1'b1;
              end else begin
                // Leave half a bit early so a back-to-back start edge is seen.
                p_data     <= shreg;
                par_error  <= par_en_q & ((^{shreg, pbit}) ^ (par_typ_q == PAR_ODD));
                stop_error <= stop_err_now;
                data_valid <= 1'b1;
                state      <= ST_IDLE;
                busy       <= 1'b0;
              end
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  localparam int DATA_W = 8;
  localparam int OS     = 16;
  localparam int DIV_W  = 16;

  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic        pbit;
    logic        stop2;
    logic        stop_a;
    logic        stop_b;
    logic        corrupt;
    logic [15:0] dv;
    logic        exp_perr;
    logic        exp_serr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  div;
  logic              par_en;
  logic              par_typ;
  logic              stop2;
  logic              rx_in;
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              par_error;
  logic              stop_error;
  logic              busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [7:0] last_data = 8'h00;
  vec_t vecs[9];

  uart_rx_os #(.DATA_W(DATA_W), .OS(OS), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div        (div),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop2      (stop2),
    .rx_in      (rx_in),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_error  (par_error),
    .stop_error (stop_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual=%0h required=none", p_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("p_data", 32'(p_data), 32'(e.data));
        check("par_error", 32'(par_error), 32'(e.perr));
        check("stop_error", 32'(stop_error), 32'(e.serr));
      end
    end
  end

  task automatic hold_line(input logic b, input int slots);
    rx_in = b;
    repeat (slots) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    int   bt;
    logic bq[$];
    exp_t e;
    bt      = OS * (int'(v.dv) + 1);
    div     = v.dv;
    par_en  = v.par_en;
    par_typ = v.par_typ;
    stop2   = v.stop2;
    bq.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bq.push_back(v.data[i]);
    if (v.par_en) bq.push_back(v.pbit);
    bq.push_back(v.stop_a);
    if (v.stop2) bq.push_back(v.stop_b);
    e.data = v.data;
    e.perr = v.exp_perr;
    e.serr = v.exp_serr;
    sb.push_back(e);
    last_data = v.data;
    foreach (bq[k]) begin
      for (int j = 0; j < bt; j++) begin
        // Slot OS/2+1 of each bit reaches the middle vote sample (div=0).
        rx_in = (v.corrupt && j == OS/2 + 1) ? ~bq[k] : bq[k];
        @(posedge clk);
        #1;
      end
    end
    hold_line(1'b1, 2 * bt);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ff;
    int   n;

    //          data   pe    pt    pb    s2    sa    sb    cor   dv     perr  serr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1};
    vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0};
    vecs[8] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};

    rst = 1'b0; en = 1'b1; div = '0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_par_error", 32'(par_error), 32'd0);
    check("rst_stop_error", 32'(stop_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    hold_line(1'b1, 20);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i]);
      drain("frame_drain");
    end

    // Short low glitch: start detected, rejected at the mid-start vote.
    hold_line(1'b0, 5);
    rx_in = 1'b1;
    check("glitch_busy_hi", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("glitch_busy_drop", 32'(busy), 32'd0);
    hold_line(1'b1, 40);
    check("glitch_busy_stays", 32'(busy), 32'd0);
    check("glitch_hold", 32'(p_data), 32'(last_data));

    // Abort with en low in the middle of data bit 4.
    hold_line(1'b0, OS * 5 + OS / 2);
    check("abort_busy_before", 32'(busy), 32'd1);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hold", 32'(p_data), 32'(last_data));
    hold_line(1'b1, 3 * OS);
    en = 1'b1;
    hold_line(1'b1, OS);
    check("abort_idle", 32'(busy), 32'd0);
    ff = vecs[0];
    ff.data = 8'hFF;
    send_frame(ff);
    drain("restart_drain");

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    hold_line(1'b0, 40);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_p_data", 32'(p_data), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_par_error", 32'(par_error), 32'd0);
    check("rstmid_stop_error", 32'(stop_error), 32'd0);
    check("rstmid_data_valid", 32'(data_valid), 32'd0);
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold_line(1'b1, 20);

    send_frame(vecs[7]);
    drain("div3_drain");
    send_frame(vecs[8]);
    drain("stop2_ok_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
